// File: rtl/mnist_image_streamer_if.sv
// mnist_image_streamer_if
//   Bundles the streamer's host-side buffer/control signals, the link to the
//   MNIST core (ui_in / uio_in[7] out, uio_out[3:0] / uo_out in) and the
//   captured result into one interface.
//   slave  : the streamer itself
//   master : everything around it (host logic, core, testbench)
//   Signals:
//     wr_en, wr_addr[6:0], wr_data[7:0] : buffer write port
//     start                             : begin a transfer
//     busy, done                        : transfer status
//     pixels[7:0], load                 : byte stream into the core
//     dut_index[3:0], dut_value[7:0]    : core class / score
//     result_index[3:0], result_value[7:0] : captured class / score
interface mnist_image_streamer_if;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] pixels;
  logic       load;
  logic [3:0] dut_index;
  logic [7:0] dut_value;
  logic [3:0] result_index;
  logic [7:0] result_value;

  modport master (
    output wr_en, wr_addr, wr_data, start, dut_index, dut_value,
    input  busy, done, pixels, load, result_index, result_value
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, dut_index, dut_value,
    output busy, done, pixels, load, result_index, result_value
  );
endinterface

// File: rtl/mnist_image_streamer.sv
// mnist_image_streamer
//   Holds one binarized MNIST image (BYTES bytes, bit i of byte a = pixel
//   8*a+i, row-major) and on start streams it into the core one byte per
//   load strobe, GAP idle cycles between bytes. With capture built in, it
//   then waits RESULT_WAIT cycles and registers the core's class/score.
//   Build option: define MNIST_STREAMER_CAPTURE_EN to build the WAIT state
//   and result capture; otherwise DONE follows the last byte directly and
//   the result outputs are tied to zero.
//   Ports:
//     i_clk   : clock, rising edge
//     i_reset : synchronous, active-high
//     bus     : mnist_image_streamer_if.slave (write port, start, status,
//               pixel stream, core result in, captured result out)
module mnist_image_streamer #(
  parameter int BYTES       = 98,  // image length, <= 128
  parameter int GAP         = 0,   // idle cycles between bytes
  parameter int RESULT_WAIT = 16   // settle cycles before capture, >= 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  mnist_image_streamer_if.slave   bus
);

  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST  = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [7:0]    BYTES_W   = 8'(BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [3:0] index;
    logic [7:0] value;
  } result_t;

  state_t        r_state, w_next;
  logic [7:0]    r_buf [BYTES];
  logic [CW-1:0] r_count;
  logic [GW-1:0] r_gcnt;
  logic [7:0]    r_pixels;
  logic [7:0]    w_rd_byte;
  logic          w_last_byte;
  logic          w_wr_ok;

`ifdef MNIST_STREAMER_CAPTURE_EN
  localparam int WW = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST  = WW'(RESULT_WAIT - 1);
  localparam state_t        AFTER_SEND = S_WAIT;
  logic [WW-1:0] r_wcnt;
  result_t       r_result;
`else
  localparam state_t        AFTER_SEND = S_DONE;
`endif

  assign w_rd_byte   = r_buf[r_count];
  assign w_last_byte = (r_count == LAST_BYTE);

  // Buffer writes only when not streaming; out-of-range addresses dropped.
  // A write in the start cycle lands before the first read, so the
  // streamed image reflects it.
  assign w_wr_ok = bus.wr_en && (r_state == S_IDLE || r_state == S_DONE) &&
                   ({1'b0, bus.wr_addr} < BYTES_W);

  // Buffer has no reset: image survives a reset of the control path.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_buf[bus.wr_addr[CW-1:0]] <= bus.wr_data;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (bus.start) w_next = S_SEND;
      S_SEND: begin
        if (w_last_byte)  w_next = AFTER_SEND;
        else if (GAP > 0) w_next = S_GAP;
      end
      S_GAP:  if (r_gcnt == GAP_LAST) w_next = S_SEND;
`ifdef MNIST_STREAMER_CAPTURE_EN
      S_WAIT: if (r_wcnt == WAIT_LAST) w_next = S_DONE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Byte / gap counters and last-byte hold register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count  <= '0;
      r_gcnt   <= '0;
      r_pixels <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (bus.start) r_count <= '0;
        S_SEND: begin
          r_pixels <= w_rd_byte;
          r_gcnt   <= '0;
          // with no gap the next byte follows immediately
          if (!w_last_byte && GAP == 0) r_count <= r_count + 1'b1;
        end
        S_GAP: begin
          if (r_gcnt == GAP_LAST) r_count <= r_count + 1'b1;
          else                    r_gcnt  <= r_gcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- result capture ----------------
`ifdef MNIST_STREAMER_CAPTURE_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wcnt   <= '0;
      r_result <= '0;
    end else if (r_state == S_SEND) begin
      r_wcnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wcnt <= r_wcnt + 1'b1;
      // core output sampled on the last settle cycle; held until next capture
      if (r_wcnt == WAIT_LAST) r_result <= {bus.dut_index, bus.dut_value};
    end
  end

  assign bus.result_index = r_result.index;
  assign bus.result_value = r_result.value;
`else
  wire w_unused_dut = ^{bus.dut_index, bus.dut_value};
  assign bus.result_index = '0;
  assign bus.result_value = '0;
`endif

  // ---------------- outputs ----------------
  assign bus.load   = (r_state == S_SEND);
  assign bus.pixels = (r_state == S_SEND) ? w_rd_byte : r_pixels;
  assign bus.busy   = (r_state == S_SEND) || (r_state == S_GAP) || (r_state == S_WAIT);
  assign bus.done   = (r_state == S_DONE);

endmodule
